// File: rtl/riscv_mem_pkg.sv
// Shared definitions for the MEM stage: RV32 load/store funct3 codes and FSM states.
package riscv_mem_pkg;

  // RV32 load/store width encodings (funct3)
  localparam logic [2:0] LS_B  = 3'b000;
  localparam logic [2:0] LS_H  = 3'b001;
  localparam logic [2:0] LS_W  = 3'b010;
  localparam logic [2:0] LS_BU = 3'b100;
  localparam logic [2:0] LS_HU = 3'b101;

  // MEM stage access sequencer states
  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    REQ        = 2'd1,
    WAIT_RDATA = 2'd2,
    DONE       = 2'd3
  } state_t;

endpackage

// File: rtl/load_store_align.sv
// Byte-lane steering for the data memory port.
//   ls_type    : funct3 of the access
//   off        : byte offset inside the word (addr[1:0])
//   store_data : rs2 value to store
//   rdata      : word returned by memory
//   be/wdata   : byte enables and lane-replicated store data
//   load_data  : extracted and extended load result
//   misaligned : half access on an odd address or word access off a word boundary
module load_store_align
  import riscv_mem_pkg::*;
(
  input  logic [2:0]  ls_type,
  input  logic [1:0]  off,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic        misaligned
);

  logic        is_half;
  logic        is_word;
  logic        is_signed;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    is_half   = (ls_type == LS_H) || (ls_type == LS_HU);
    is_word   = (ls_type == LS_W);
    is_signed = (ls_type == LS_B) || (ls_type == LS_H);
    byte_sel  = rdata[{off, 3'b000} +: 8];
    // A legal halfword sits in either the low or the high half of the word
    half_sel  = off[1] ? rdata[31:16] : rdata[15:0];

    // Byte access is the fallback for any width code that is not H/HU/W
    be         = 4'b0001 << off;
    wdata      = {4{store_data[7:0]}};
    load_data  = {{24{is_signed & byte_sel[7]}}, byte_sel};
    misaligned = 1'b0;

    if (is_half) begin
      be         = 4'b0011 << off;
      wdata      = {2{store_data[15:0]}};
      load_data  = {{16{is_signed & half_sel[15]}}, half_sel};
      misaligned = off[0];
    end else if (is_word) begin
      be         = 4'b1111;
      wdata      = store_data;
      load_data  = rdata;
      misaligned = |off;
    end
  end

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: sequences one data-memory access per instruction and
// produces the registered result bundle for the MEM/WB register.
//   CLK, RESET            : clock, synchronous active-high reset
//   valid_i .. RegDst_i   : EX/MEM register contents (sampled only in IDLE)
//   stall_o               : holds EX/MEM and earlier stages (combinational)
//   dmem_*                : request/ready/rvalid data memory port
//   out_valid .. bus_error: registered result bundle for MEM/WB
module mem_access_stage
  import riscv_mem_pkg::*;
#(
  parameter int unsigned XLEN           = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            valid_i,
  input  logic            MemRead_i,
  input  logic            MemWrite_i,
  input  logic [2:0]      LoadOrStoreTYPE_i,
  input  logic [XLEN-1:0] ALUResult_i,
  input  logic [XLEN-1:0] StoreData_i,
  input  logic [4:0]      WB_control_i,
  input  logic [4:0]      RegDst_i,
  output logic            stall_o,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [3:0]      dmem_be,
  output logic [XLEN-1:0] dmem_wdata,
  input  logic            dmem_ready,
  input  logic            dmem_rvalid,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic            out_valid,
  output logic [XLEN-1:0] LoadData,
  output logic [XLEN-1:0] ALUResult,
  output logic [4:0]      WB_control,
  output logic [4:0]      RegDst,
  output logic            misaligned,
  output logic            bus_error
);

  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  state_t           state;
  logic [2:0]       cap_type;
  logic [1:0]       cap_off;
  logic [TMO_W-1:0] tmo_cnt;

  logic             mem_op_c;
  logic             tmo_hit_c;
  logic [2:0]       al_type_c;
  logic [1:0]       al_off_c;
  logic [3:0]       al_be_c;
  logic [XLEN-1:0]  al_wdata_c;
  logic [XLEN-1:0]  al_load_c;
  logic             al_mis_c;

  assign mem_op_c  = valid_i & (MemRead_i | MemWrite_i);
  assign tmo_hit_c = (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

  // One aligner serves both directions: live inputs while deciding in IDLE,
  // captured type/offset while the load data is coming back.
  assign al_type_c = (state == IDLE) ? LoadOrStoreTYPE_i : cap_type;
  assign al_off_c  = (state == IDLE) ? ALUResult_i[1:0]  : cap_off;

  load_store_align u_align (
    .ls_type    (al_type_c),
    .off        (al_off_c),
    .store_data (StoreData_i),
    .rdata      (dmem_rdata),
    .be         (al_be_c),
    .wdata      (al_wdata_c),
    .load_data  (al_load_c),
    .misaligned (al_mis_c)
  );

  // Stall from the capture cycle until DONE; DONE lets upstream advance
  assign stall_o = ((state == IDLE) & mem_op_c & ~al_mis_c)
                 | (state == REQ) | (state == WAIT_RDATA);

  // Access sequencer, request port and result bundle
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state      <= IDLE;
      cap_type   <= '0;
      cap_off    <= '0;
      tmo_cnt    <= '0;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_be    <= '0;
      dmem_wdata <= '0;
      out_valid  <= 1'b0;
      LoadData   <= '0;
      ALUResult  <= '0;
      WB_control <= '0;
      RegDst     <= '0;
      misaligned <= 1'b0;
      bus_error  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          bus_error <= 1'b0;
          if (valid_i) begin
            ALUResult  <= ALUResult_i;
            WB_control <= WB_control_i;
            RegDst     <= RegDst_i;
            LoadData   <= '0;
          end
          if (valid_i && (!mem_op_c || al_mis_c)) begin
            // Result available without touching the bus
            out_valid  <= 1'b1;
            misaligned <= mem_op_c & al_mis_c;
          end else if (mem_op_c) begin
            out_valid  <= 1'b0;
            misaligned <= 1'b0;
            cap_type   <= LoadOrStoreTYPE_i;
            cap_off    <= ALUResult_i[1:0];
            tmo_cnt    <= '0;
            dmem_req   <= 1'b1;
            dmem_we    <= MemWrite_i;
            dmem_addr  <= {ALUResult_i[XLEN-1:2], 2'b00};
            dmem_be    <= al_be_c;
            dmem_wdata <= al_wdata_c;
            state      <= REQ;
          end else begin
            out_valid  <= 1'b0;
            misaligned <= 1'b0;
          end
        end

        REQ: begin
          if (dmem_ready) begin
            dmem_req <= 1'b0;
            dmem_we  <= 1'b0;
            dmem_be  <= '0;
            tmo_cnt  <= '0;
            if (dmem_we) begin
              out_valid <= 1'b1;
              state     <= DONE;
            end else if (dmem_rvalid) begin
              out_valid <= 1'b1;
              LoadData  <= al_load_c;
              state     <= DONE;
            end else begin
              state <= WAIT_RDATA;
            end
          end else if (tmo_hit_c) begin
            dmem_req  <= 1'b0;
            dmem_we   <= 1'b0;
            dmem_be   <= '0;
            out_valid <= 1'b1;
            bus_error <= 1'b1;
            state     <= DONE;
          end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
          end
        end

        WAIT_RDATA: begin
          if (dmem_rvalid) begin
            out_valid <= 1'b1;
            LoadData  <= al_load_c;
            state     <= DONE;
          end else if (tmo_hit_c) begin
            out_valid <= 1'b1;
            bus_error <= 1'b1;
            state     <= DONE;
          end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
          end
        end

        DONE: begin
          out_valid  <= 1'b0;
          misaligned <= 1'b0;
          bus_error  <= 1'b0;
          state      <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: directed instructions, a reactive
// memory responder, and a scoreboard of expected result bundles.
module tb_mem_access_stage;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        valid_i, MemRead_i, MemWrite_i;
  logic [2:0]  LoadOrStoreTYPE_i;
  logic [31:0] ALUResult_i, StoreData_i;
  logic [4:0]  WB_control_i, RegDst_i;
  logic        stall_o, dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ready, dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic        out_valid;
  logic [31:0] LoadData, ALUResult;
  logic [4:0]  WB_control, RegDst;
  logic        misaligned, bus_error;

  mem_access_stage #(.XLEN(32), .TIMEOUT_CYCLES(4)) dut (
    .CLK(CLK), .RESET(RESET), .valid_i(valid_i), .MemRead_i(MemRead_i),
    .MemWrite_i(MemWrite_i), .LoadOrStoreTYPE_i(LoadOrStoreTYPE_i),
    .ALUResult_i(ALUResult_i), .StoreData_i(StoreData_i),
    .WB_control_i(WB_control_i), .RegDst_i(RegDst_i), .stall_o(stall_o),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_be(dmem_be), .dmem_wdata(dmem_wdata), .dmem_ready(dmem_ready),
    .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata), .out_valid(out_valid),
    .LoadData(LoadData), .ALUResult(ALUResult), .WB_control(WB_control),
    .RegDst(RegDst), .misaligned(misaligned), .bus_error(bus_error)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] alu;
    logic [31:0] ld;
    logic [4:0]  wb;
    logic [4:0]  rd;
    logic        mis;
    logic        berr;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_err    = 0;
  int   pending  = 0;   // 1: immediate result due next cycle, 2: no result due

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, expv);
    end
  endtask

  // ---- reference model (access rules expressed arithmetically) ----
  function automatic int unsigned f_size(input logic [2:0] t);
    case (t)
      3'b001, 3'b101: return 2;
      3'b010:         return 4;
      default:        return 1;
    endcase
  endfunction

  function automatic logic f_mis(input logic [2:0] t, input logic [31:0] a);
    return (a % f_size(t)) != 0;
  endfunction

  function automatic logic [3:0] f_be(input logic [2:0] t, input logic [31:0] a);
    int unsigned m;
    m = ((32'd1 << f_size(t)) - 1) << (a % 4);
    return 4'(m);
  endfunction

  function automatic logic [31:0] f_wdata(input logic [2:0] t, input logic [31:0] sd);
    case (f_size(t))
      1:       return (sd & 32'h0000_00FF) * 32'h0101_0101;
      2:       return (sd & 32'h0000_FFFF) * 32'h0001_0001;
      default: return sd;
    endcase
  endfunction

  function automatic logic [31:0] f_load(input logic [2:0] t, input logic [31:0] a, input logic [31:0] rd);
    longint x, span;
    x    = longint'({32'd0, rd}) >> (8 * (a % 4));
    span = longint'(1) << (8 * f_size(t));
    x    = x % span;
    if ((t == 3'b000 || t == 3'b001) && x >= span / 2) x = x - span;
    return 32'(x);
  endfunction

  // ---- scoreboard compare: every valid result bundle ----
  always @(negedge CLK) begin
    if (!RESET && out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_out_valid", 32'(out_valid), 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("ALUResult",  ALUResult, e.alu);
        chk("LoadData",   LoadData, e.ld);
        chk("WB_control", 32'(WB_control), 32'(e.wb));
        chk("RegDst",     32'(RegDst), 32'(e.rd));
        chk("misaligned", 32'(misaligned), 32'(e.mis));
        chk("bus_error",  32'(bus_error), 32'(e.berr));
      end
    end
  end

  task automatic resolve_pending();
    if (pending == 1) chk("imm_out_valid", 32'(out_valid), 32'd1);
    if (pending == 2) chk("idle_out_valid", 32'(out_valid), 32'd0);
    pending = 0;
  endtask

  task automatic idle_cycle();
    @(posedge CLK); #1;
    valid_i = 1'b0; MemRead_i = 1'b0; MemWrite_i = 1'b0;
    @(negedge CLK);
    resolve_pending();
    pending = 2;
  endtask

  // rdy_on: REQ cycle (1-based) in which ready is given, 0 = never.
  // rv_dly: cycles after the ready cycle that rvalid arrives, -1 = never.
  task automatic do_op(input logic v, input logic rd, input logic wr,
                       input logic [2:0] t, input logic [31:0] a, input logic [31:0] sd,
                       input logic [4:0] wb, input logic [4:0] dst, input logic [31:0] rdat,
                       input int rdy_on, input int rv_dly,
                       output int stall_n, output int req_n,
                       output logic [3:0] seen_be, output logic [31:0] seen_wd);
    exp_t e;
    logic mem, mis, berr, done, ready_seen, first;
    int   since, cyc;
    mem  = v & (rd | wr);
    mis  = mem && f_mis(t, a);
    berr = mem && !mis && (rdy_on == 0 || (!wr && rv_dly < 0));
    if (v) begin
      e.alu = a; e.wb = wb; e.rd = dst; e.mis = mis; e.berr = berr;
      e.ld  = (mem && !wr && !mis && !berr) ? f_load(t, a, rdat) : 32'd0;
      exp_q.push_back(e);
    end
    @(posedge CLK); #1;
    valid_i = v; MemRead_i = rd; MemWrite_i = wr; LoadOrStoreTYPE_i = t;
    ALUResult_i = a; StoreData_i = sd; WB_control_i = wb; RegDst_i = dst;
    dmem_ready = 1'b0; dmem_rvalid = 1'b0;
    stall_n = 0; req_n = 0; seen_be = '0; seen_wd = '0;
    ready_seen = 1'b0; since = 0; cyc = 0; done = 1'b0; first = 1'b1;
    while (!done) begin
      @(negedge CLK);
      if (first) begin resolve_pending(); first = 1'b0; end
      cyc++;
      if (dmem_req) begin
        req_n++;
        if (!(mem && !mis)) chk("unexpected_req", 32'(dmem_req), 32'd0);
        else begin
          chk("req_addr", dmem_addr, a & 32'hFFFF_FFFC);
          chk("req_we", 32'(dmem_we), 32'(wr));
          if (wr) begin
            chk("req_be", 32'(dmem_be), 32'(f_be(t, a)));
            chk("req_wdata", dmem_wdata, f_wdata(t, sd));
          end
          seen_be = dmem_be; seen_wd = dmem_wdata;
        end
      end
      dmem_ready = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 32'hA5A5_5A5A;
      if (stall_o === 1'b1) begin
        stall_n++;
        if (dmem_req && rdy_on != 0 && req_n == rdy_on) begin
          dmem_ready = 1'b1; ready_seen = 1'b1; since = 0;
          if (!wr && rv_dly == 0) begin dmem_rvalid = 1'b1; dmem_rdata = rdat; end
        end else if (ready_seen && !wr) begin
          since++;
          if (rv_dly > 0 && since == rv_dly) begin dmem_rvalid = 1'b1; dmem_rdata = rdat; end
        end
        if (cyc > 40) begin
          n_checks++; n_err++;
          $display("FAIL op_cycle_bound: stall_o still 1 after %0d cycles, required release", cyc);
          done = 1'b1;
        end
      end else begin
        done = 1'b1;
        if (mem && !mis) chk("done_out_valid", 32'(out_valid), 32'd1);
        else pending = v ? 1 : 2;
      end
    end
  endtask

  int          st, rq;
  logic [3:0]  sbe;
  logic [31:0] swd;

  initial begin
    RESET = 1'b1; valid_i = 0; MemRead_i = 0; MemWrite_i = 0; LoadOrStoreTYPE_i = 0;
    ALUResult_i = 0; StoreData_i = 0; WB_control_i = 0; RegDst_i = 0;
    dmem_ready = 0; dmem_rvalid = 0; dmem_rdata = 0;
    repeat (3) @(posedge CLK);
    #1 RESET = 1'b0;
    @(negedge CLK);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_dmem_req", 32'(dmem_req), 32'd0);
    chk("rst_dmem_we_be", {27'd0, dmem_we, dmem_be}, 32'd0);
    chk("rst_flags", {30'd0, misaligned, bus_error}, 32'd0);
    chk("rst_result", ALUResult | LoadData, 32'd0);
    chk("rst_stall", 32'(stall_o), 32'd0);

    // SW, ready on 2nd REQ cycle
    do_op(1,0,1, 3'b010, 32'h1004, 32'hDEAD_BEEF, 5'h11, 5'd3, 0, 2, 0, st, rq, sbe, swd);
    chk("sw_stall_cycles", st, 3);
    chk("sw_be", 32'(sbe), 32'hF);
    chk("sw_misaligned", 32'(misaligned), 32'd0);
    // LB / LBU at 0x2003, rvalid 2 cycles after ready
    do_op(1,1,0, 3'b000, 32'h2003, 0, 5'h01, 5'd4, 32'h80FF_0000, 1, 2, st, rq, sbe, swd);
    chk("lb_stall_cycles", st, 4);
    chk("lb_loaddata", LoadData, 32'hFFFF_FF80);
    do_op(1,1,0, 3'b100, 32'h2003, 0, 5'h01, 5'd5, 32'h80FF_0000, 1, 2, st, rq, sbe, swd);
    chk("lbu_loaddata", LoadData, 32'h0000_0080);
    // SH lanes, then misaligned LH
    do_op(1,0,1, 3'b001, 32'h3002, 32'h0000_1234, 5'h02, 5'd6, 0, 1, 0, st, rq, sbe, swd);
    chk("sh_be", 32'(sbe), 32'hC);
    chk("sh_wdata", swd, 32'h1234_1234);
    do_op(1,1,0, 3'b001, 32'h3001, 0, 5'h03, 5'd7, 0, 1, 0, st, rq, sbe, swd);
    chk("lh_mis_req_cycles", rq, 0);
    idle_cycle();
    chk("lh_mis_flag", 32'(misaligned), 32'd1);
    // Non-memory op then LW with ready+rvalid together
    do_op(1,0,0, 3'b000, 32'h55, 0, 5'h04, 5'd8, 0, 0, 0, st, rq, sbe, swd);
    do_op(1,1,0, 3'b010, 32'h5008, 0, 5'h05, 5'd9, 32'hCAFE_F00D, 1, 0, st, rq, sbe, swd);
    chk("lw_fast_stall", st, 2);
    chk("lw_fast_loaddata", LoadData, 32'hCAFE_F00D);
    // LW with no ready: timeout in REQ
    do_op(1,1,0, 3'b010, 32'h6000, 0, 5'h06, 5'd10, 0, 0, 0, st, rq, sbe, swd);
    chk("tmo_req_cycles", rq, 4);
    chk("tmo_stall", st, 5);
    chk("tmo_bus_error", 32'(bus_error), 32'd1);
    chk("tmo_loaddata", LoadData, 32'd0);
    // Halfword loads from the upper half
    do_op(1,1,0, 3'b001, 32'h7002, 0, 5'h07, 5'd11, 32'h8001_1234, 1, 1, st, rq, sbe, swd);
    chk("lh_hi_loaddata", LoadData, 32'hFFFF_8001);
    do_op(1,1,0, 3'b101, 32'h7002, 0, 5'h07, 5'd12, 32'h8001_1234, 1, 1, st, rq, sbe, swd);
    chk("lhu_hi_loaddata", LoadData, 32'h0000_8001);
    // SB lane 1, ready on 3rd REQ cycle
    do_op(1,0,1, 3'b000, 32'h8001, 32'h0000_00AB, 5'h08, 5'd13, 0, 3, 0, st, rq, sbe, swd);
    chk("sb_be", 32'(sbe), 32'h2);
    chk("sb_wdata", swd, 32'hABAB_ABAB);
    chk("sb_stall", st, 4);
    // Misaligned SW
    do_op(1,0,1, 3'b010, 32'h9002, 32'h1, 5'h09, 5'd14, 0, 1, 0, st, rq, sbe, swd);
    idle_cycle();
    chk("sw_mis_flag", 32'(misaligned), 32'd1);
    // LW with no rvalid: timeout in WAIT_RDATA
    do_op(1,1,0, 3'b010, 32'hA000, 0, 5'h0A, 5'd15, 0, 1, -1, st, rq, sbe, swd);
    chk("tmo_wait_stall", st, 6);
    chk("tmo_wait_bus_error", 32'(bus_error), 32'd1);
    // Read and write both set: behaves as a store
    do_op(1,1,1, 3'b010, 32'hB000, 32'h1122_3344, 5'h0B, 5'd16, 0, 1, 0, st, rq, sbe, swd);
    chk("rw_store_loaddata", LoadData, 32'd0);
    do_op(0,0,0, 3'b000, 32'h0, 0, 5'h00, 5'd0, 0, 0, 0, st, rq, sbe, swd);

    // Reset while waiting for read data; late rvalid must be ignored
    @(posedge CLK); #1;
    valid_i = 1; MemRead_i = 1; MemWrite_i = 0; LoadOrStoreTYPE_i = 3'b010; ALUResult_i = 32'hC000;
    @(negedge CLK); resolve_pending();
    chk("rst_seq_stall", 32'(stall_o), 32'd1);
    @(negedge CLK);
    chk("rst_seq_req", 32'(dmem_req), 32'd1);
    dmem_ready = 1'b1;
    @(posedge CLK); #1 dmem_ready = 1'b0;
    @(negedge CLK);
    chk("rst_seq_wait_req", 32'(dmem_req), 32'd0);
    chk("rst_seq_wait_stall", 32'(stall_o), 32'd1);
    RESET = 1'b1; valid_i = 1'b0;
    @(posedge CLK); #1 RESET = 1'b0;
    @(negedge CLK);
    chk("rst2_stall", 32'(stall_o), 32'd0);
    chk("rst2_outs", {28'd0, out_valid, dmem_req, misaligned, bus_error}, 32'd0);
    chk("rst2_be", 32'(dmem_be), 32'd0);
    chk("rst2_data", LoadData | ALUResult, 32'd0);
    dmem_rvalid = 1'b1; dmem_rdata = 32'h1234_5678;
    @(posedge CLK); #1 dmem_rvalid = 1'b0;
    repeat (3) begin
      @(negedge CLK);
      chk("late_rvalid_out_valid", 32'(out_valid), 32'd0);
    end
    chk("scoreboard_drained", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
